// File: rtl/accel_host_pkg.sv
// Shared constants for the host-side layer sequencer: default job geometry
// and the FSM state encoding.
package accel_host_pkg;

  localparam int KERNEL_SIZE = 3;
  localparam int ACT_SIZE    = 5;
  localparam int W_WORDS     = KERNEL_SIZE ** 2;
  localparam int A_WORDS     = ACT_SIZE ** 2;
  localparam int LD_EXTRA    = 3;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WR_WGHT  = 4'd1;
  localparam logic [3:0] S_WR_IACT  = 4'd2;
  localparam logic [3:0] S_LD_WGHT  = 4'd3;
  localparam logic [3:0] S_WAIT_WLD = 4'd4;
  localparam logic [3:0] S_LD_IACT  = 4'd5;
  localparam logic [3:0] S_WAIT_ALD = 4'd6;
  localparam logic [3:0] S_START    = 4'd7;
  localparam logic [3:0] S_WAIT_CMP = 4'd8;
  localparam logic [3:0] S_RD_REQ   = 4'd9;
  localparam logic [3:0] S_RD_CAP   = 4'd10;
  localparam logic [3:0] S_RD_OUT   = 4'd11;
  localparam logic [3:0] S_FIN      = 4'd12;

endpackage

// File: rtl/accel_host_seq_edge.sv
// Rising-edge detector: flags a 0->1 transition of a level input, so a level
// that was already high in the previous cycle never counts as an event.
module edge_rise_det (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/accel_host_seq.sv
// Host sequencer for one layer job on main_local: GLB weight/iact writes,
// spad loads, NUM_ITER compute passes and psum readback onto an output stream.
module accel_host_seq
  import accel_host_pkg::*;
#(
  parameter int DATA_BITWIDTH  = 16,
  parameter int ADDR_BITWIDTH  = 6,
  parameter int W_LOAD_ADDR    = 0,
  parameter int A_LOAD_ADDR    = 10,
  parameter int PSUM_LOAD_ADDR = 0,
  parameter int kernel_size    = KERNEL_SIZE,
  parameter int act_size       = ACT_SIZE,
  parameter int X_dim          = 3,
  parameter int NUM_ITER       = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_start,
  output logic                     busy,
  output logic                     job_done,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_BITWIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BITWIDTH-1:0] out_data,
  output logic                     write_en_wght,
  output logic                     write_en_iact,
  output logic [ADDR_BITWIDTH-1:0] w_addr_wght,
  output logic [ADDR_BITWIDTH-1:0] w_addr_iact,
  output logic [DATA_BITWIDTH-1:0] w_data_wght,
  output logic [DATA_BITWIDTH-1:0] w_data_iact,
  output logic                     val_enable_i_val_0_wght,
  output logic                     val_enable_i_val_0_iact,
  output logic                     start,
  input  logic                     load_done,
  input  logic                     compute_done,
  output logic                     val_0_req_read_psum,
  output logic [ADDR_BITWIDTH-1:0] r_addr_psum,
  input  logic [DATA_BITWIDTH-1:0] r_data_psum,
  output logic [3:0]               fsm_state
);

  localparam logic [7:0] W_LAST    = 8'(kernel_size * kernel_size - 1);
  localparam logic [7:0] A_LAST    = 8'(act_size * act_size - 1);
  localparam logic [7:0] WLD_LAST  = 8'(kernel_size * kernel_size + LD_EXTRA - 1);
  localparam logic [7:0] ALD_LAST  = 8'(act_size * act_size + LD_EXTRA - 1);
  localparam logic [7:0] X_LAST    = 8'(X_dim - 1);
  localparam logic [7:0] ITER_LAST = 8'(NUM_ITER - 1);

  logic [3:0] state;
  logic [7:0] n, cyc, col, iter;
  logic       load_rise, cmp_rise, beat;

  // Both streams: a beat transfers on a rising clk edge where valid and ready
  // are both high; the sender holds data stable while valid waits for ready.
  assign beat      = in_valid & in_ready;
  assign fsm_state = state;

  edge_rise_det u_load_edge (.clk(clk), .reset(reset), .level(load_done),    .rise(load_rise));
  edge_rise_det u_cmp_edge  (.clk(clk), .reset(reset), .level(compute_done), .rise(cmp_rise));

  function automatic logic [ADDR_BITWIDTH-1:0] psum_addr(input logic [7:0] it, input logic [7:0] c);
    return ADDR_BITWIDTH'(PSUM_LOAD_ADDR + int'(it) * X_dim + int'(c));
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      n <= '0; cyc <= '0; col <= '0; iter <= '0;
      busy <= 1'b0; job_done <= 1'b0; in_ready <= 1'b0;
      out_valid <= 1'b0; out_data <= '0;
      write_en_wght <= 1'b0; write_en_iact <= 1'b0;
      w_addr_wght <= '0; w_addr_iact <= '0; w_data_wght <= '0; w_data_iact <= '0;
      val_enable_i_val_0_wght <= 1'b0; val_enable_i_val_0_iact <= 1'b0;
      start <= 1'b0; val_0_req_read_psum <= 1'b0; r_addr_psum <= '0;
    end else begin
      write_en_wght       <= 1'b0;
      write_en_iact       <= 1'b0;
      start               <= 1'b0;
      val_0_req_read_psum <= 1'b0;
      job_done            <= 1'b0;
      case (state)
        S_IDLE: if (cmd_start) begin
          state <= S_WR_WGHT; busy <= 1'b1; in_ready <= 1'b1;
          n <= '0; cyc <= '0; col <= '0; iter <= '0;
        end
        S_WR_WGHT: if (beat) begin
          write_en_wght <= 1'b1;
          w_addr_wght   <= ADDR_BITWIDTH'(W_LOAD_ADDR + int'(n));
          w_data_wght   <= in_data;
          if (n == W_LAST) begin
            n <= '0; in_ready <= 1'b0; state <= S_WR_IACT;
          end else n <= n + 8'd1;
        end
        // in_ready was dropped for one cycle at the phase boundary; re-arm here.
        S_WR_IACT: if (beat) begin
          write_en_iact <= 1'b1;
          w_addr_iact   <= ADDR_BITWIDTH'(A_LOAD_ADDR + int'(n));
          w_data_iact   <= in_data;
          if (n == A_LAST) begin
            n <= '0; in_ready <= 1'b0; state <= S_LD_WGHT;
            val_enable_i_val_0_wght <= 1'b1; cyc <= '0;
          end else n <= n + 8'd1;
        end else in_ready <= 1'b1;
        S_LD_WGHT: if (cyc == WLD_LAST) begin
          val_enable_i_val_0_wght <= 1'b0; state <= S_WAIT_WLD;
        end else cyc <= cyc + 8'd1;
        S_WAIT_WLD: if (load_rise) begin
          state <= S_LD_IACT; val_enable_i_val_0_iact <= 1'b1; cyc <= '0;
        end
        S_LD_IACT: if (cyc == ALD_LAST) begin
          val_enable_i_val_0_iact <= 1'b0; state <= S_WAIT_ALD;
        end else cyc <= cyc + 8'd1;
        S_WAIT_ALD: if (load_rise) begin
          state <= S_START; start <= 1'b1;
        end
        S_START: state <= S_WAIT_CMP;
        S_WAIT_CMP: if (cmp_rise) begin
          state <= S_RD_REQ; val_0_req_read_psum <= 1'b1; r_addr_psum <= psum_addr(iter, col);
        end
        S_RD_REQ: state <= S_RD_CAP;
        S_RD_CAP: begin
          out_data <= r_data_psum; out_valid <= 1'b1; state <= S_RD_OUT;
        end
        S_RD_OUT: if (out_ready) begin
          out_valid <= 1'b0;
          if (col == X_LAST) begin
            col  <= '0;
            iter <= iter + 8'd1;
            if (iter == ITER_LAST) begin
              state <= S_FIN; job_done <= 1'b1; busy <= 1'b0;
            end else begin
              state <= S_START; start <= 1'b1;
            end
          end else begin
            col <= col + 8'd1; state <= S_RD_REQ;
            val_0_req_read_psum <= 1'b1; r_addr_psum <= psum_addr(iter, col + 8'd1);
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
